// File: rtl/ps2_pkg.sv
// ps2_pkg: shared definitions for the PS/2 scan-code path (set-2 codes,
// game-control key indices, decoder FSM encoding, key-lookup result).
package ps2_pkg;

  // Prefix bytes
  localparam logic [7:0] SC_BREAK = 8'hF0;
  localparam logic [7:0] SC_EXT   = 8'hE0;

  // Mapped set-2 codes (arrows need the E0 prefix, the rest must not have it)
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_RIGHT = 8'h74;
  localparam logic [7:0] SC_UP    = 8'h75;
  localparam logic [7:0] SC_DOWN  = 8'h72;
  localparam logic [7:0] SC_SPACE = 8'h29;
  localparam logic [7:0] SC_ENTER = 8'h5A;
  localparam logic [7:0] SC_ESC   = 8'h76;
  localparam logic [7:0] SC_A     = 8'h1C;

  // Bit positions in the held-key bitmap
  localparam int         NUM_KEYS  = 8;
  localparam logic [2:0] KEY_LEFT  = 3'd0;
  localparam logic [2:0] KEY_RIGHT = 3'd1;
  localparam logic [2:0] KEY_UP    = 3'd2;
  localparam logic [2:0] KEY_DOWN  = 3'd3;
  localparam logic [2:0] KEY_SPACE = 3'd4;
  localparam logic [2:0] KEY_ENTER = 3'd5;
  localparam logic [2:0] KEY_ESC   = 3'd6;
  localparam logic [2:0] KEY_A     = 3'd7;

  // Pop/decode sequencer
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_POP    = 2'd1,
    S_DECODE = 2'd2
  } ps2_state_t;

  // Result of an (ext, code) lookup
  typedef struct packed {
    logic       hit;
    logic [2:0] idx;
  } key_lookup_t;

  // True for the two prefix bytes that never map to a key by themselves
  function automatic logic is_prefix(input logic [7:0] code);
    return (code == SC_BREAK) || (code == SC_EXT);
  endfunction

endpackage

// File: rtl/ps2_key_map.sv
// ps2_key_map: combinational (ext, code) -> (hit, idx) lookup for the eight
// game-control keys. Extended codes only hit with ext=1, plain codes only
// with ext=0, so e.g. a bare 6B or an E0-prefixed 29 is a miss.
module ps2_key_map
  import ps2_pkg::*;
(
  input  logic       i_ext,
  input  logic [7:0] i_code,
  output logic       o_hit,
  output logic [2:0] o_idx
);

  key_lookup_t w_res;

  // Two separate tables selected by the extended prefix
  always_comb begin
    w_res = '{hit: 1'b0, idx: 3'd0};
    if (i_ext) begin
      case (i_code)
        SC_LEFT:  w_res = '{hit: 1'b1, idx: KEY_LEFT};
        SC_RIGHT: w_res = '{hit: 1'b1, idx: KEY_RIGHT};
        SC_UP:    w_res = '{hit: 1'b1, idx: KEY_UP};
        SC_DOWN:  w_res = '{hit: 1'b1, idx: KEY_DOWN};
        default:  w_res = '{hit: 1'b0, idx: 3'd0};
      endcase
    end else begin
      case (i_code)
        SC_SPACE: w_res = '{hit: 1'b1, idx: KEY_SPACE};
        SC_ENTER: w_res = '{hit: 1'b1, idx: KEY_ENTER};
        SC_ESC:   w_res = '{hit: 1'b1, idx: KEY_ESC};
        SC_A:     w_res = '{hit: 1'b1, idx: KEY_A};
        default:  w_res = '{hit: 1'b0, idx: 3'd0};
      endcase
    end
  end

  assign o_hit = w_res.hit;
  assign o_idx = w_res.idx;

endmodule

// File: rtl/ps2_key_decoder.sv
// ps2_key_decoder: pops set-2 scan codes from the PS/2 receiver FIFO, tracks
// the E0/F0 prefixes, keeps the held-key bitmap for the game controls and
// emits one-cycle make/break events.
// Build option: define PS2_TYPEMATIC_FILTER_EN to report events only on real
// bitmap edges (typematic repeats and breaks of idle keys stay silent).
module ps2_key_decoder
  import ps2_pkg::*;
#(
  parameter  int PREFIX_TIMEOUT = 2500000,
  localparam int CNT_W          = $clog2(PREFIX_TIMEOUT + 1)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] kb_data,
  input  logic       kb_ready,
  input  logic       kb_overflow,
  output logic       kb_rdn,
  output logic [7:0] key_state,
  output logic       key_valid,
  output logic [2:0] key_idx,
  output logic       key_released
);

  ps2_state_t       r_state;
  ps2_state_t       w_state_nxt;

  logic [7:0]       r_code;
  logic             r_rdn;
  logic [7:0]       r_keys;
  logic             r_valid;
  logic [2:0]       r_idx;
  logic             r_rel;
  logic             r_brk;
  logic             r_ext;
  logic [CNT_W-1:0] r_cnt;

  logic             w_rdn_nxt;
  logic             w_latch;
  logic             w_decode;
  logic             w_is_brk;
  logic             w_is_ext;
  logic             w_hit;
  logic [2:0]       w_idx;
  logic             w_make;
  logic             w_edge;
  logic             w_pending;
  logic             w_cnt_run;
  logic             w_timeout;

  // Lookup runs on the latched byte and the current extended flag
  ps2_key_map u_key_map (
    .i_ext  (r_ext),
    .i_code (r_code),
    .o_hit  (w_hit),
    .o_idx  (w_idx)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next state: fixed IDLE -> POP -> DECODE walk, one byte per three cycles
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (kb_ready) w_state_nxt = S_POP;
      S_POP:    w_state_nxt = S_DECODE;
      S_DECODE: w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // FSM outputs: latch/pop request in IDLE, decode strobe in DECODE
  always_comb begin
    w_rdn_nxt = 1'b1;
    w_latch   = 1'b0;
    w_decode  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (kb_ready) begin
          w_rdn_nxt = 1'b0;
          w_latch   = 1'b1;
        end
      end
      S_DECODE: w_decode = 1'b1;
      default: ;
    endcase
  end

  // Byte classification and event qualification
  always_comb begin
    w_is_brk = (r_code == SC_BREAK);
    w_is_ext = (r_code == SC_EXT);
    w_make   = ~r_brk;
`ifdef PS2_TYPEMATIC_FILTER_EN
    w_edge   = (r_keys[w_idx] != w_make);
`else
    w_edge   = 1'b1;
`endif
  end

  // Prefix timeout: only counts while a prefix waits on an empty FIFO
  assign w_pending = r_brk | r_ext;
  assign w_cnt_run = w_pending && (r_state == S_IDLE) && !kb_ready;
  assign w_timeout = w_cnt_run && (r_cnt == CNT_W'(PREFIX_TIMEOUT - 1));

  // Registered pop strobe (low during POP) and code capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rdn  <= 1'b1;
      r_code <= 8'h00;
    end else begin
      r_rdn <= w_rdn_nxt;
      if (w_latch) r_code <= kb_data;
    end
  end

  // Bitmap, prefixes and event outputs; overflow wipes state and drops the byte
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_keys  <= 8'h00;
      r_valid <= 1'b0;
      r_idx   <= 3'd0;
      r_rel   <= 1'b0;
      r_brk   <= 1'b0;
      r_ext   <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      if (kb_overflow) begin
        r_keys <= 8'h00;
        r_brk  <= 1'b0;
        r_ext  <= 1'b0;
      end else if (w_decode) begin
        if (w_is_brk) begin
          r_brk <= 1'b1;
        end else if (w_is_ext) begin
          r_ext <= 1'b1;
        end else begin
          r_brk <= 1'b0;
          r_ext <= 1'b0;
          if (w_hit) begin
            r_keys[w_idx] <= w_make;
            if (w_edge) begin
              r_valid <= 1'b1;
              r_idx   <= w_idx;
              r_rel   <= r_brk;
            end
          end
        end
      end else if (w_timeout) begin
        r_brk <= 1'b0;
        r_ext <= 1'b0;
      end
    end
  end

  // Timeout counter, cleared whenever nothing is pending or a byte lands
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (kb_overflow || w_decode || !w_pending || w_timeout) begin
      r_cnt <= '0;
    end else if (w_cnt_run) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign kb_rdn       = r_rdn;
  assign key_state    = r_keys;
  assign key_valid    = r_valid;
  assign key_idx      = r_idx;
  assign key_released = r_rel;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// tb_ps2_key_decoder: FIFO model driving the decoder, a transaction-level
// reference model predicting every output each cycle, directed scenarios with
// literal expectations, then randomized byte streams with overflow pulses.
module tb_ps2_key_decoder;

  localparam int T = 16;
`ifdef PS2_TYPEMATIC_FILTER_EN
  localparam bit FILT = 1'b1;
`else
  localparam bit FILT = 1'b0;
`endif

  // {ext, code} for key index 0..7
  localparam logic [8:0] KMAP [8] = '{9'h16B, 9'h174, 9'h175, 9'h172,
                                      9'h029, 9'h05A, 9'h076, 9'h01C};

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] kb_data = 8'h00;
  logic       kb_ready = 1'b0;
  logic       kb_overflow = 1'b0;
  logic       kb_rdn;
  logic [7:0] key_state;
  logic       key_valid;
  logic [2:0] key_idx;
  logic       key_released;

  ps2_key_decoder #(.PREFIX_TIMEOUT(T)) dut (
    .clk          (clk),
    .rst          (rst),
    .kb_data      (kb_data),
    .kb_ready     (kb_ready),
    .kb_overflow  (kb_overflow),
    .kb_rdn       (kb_rdn),
    .key_state    (key_state),
    .key_valid    (key_valid),
    .key_idx      (key_idx),
    .key_released (key_released)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  int pulses = 0;
  bit chk_en = 1'b0;

  logic [7:0] q[$];

  // Reference model: edge index e, edge at which the current byte was taken
  int         e;
  int         m_acc;
  logic [7:0] m_byte;
  logic [7:0] m_st;
  logic       m_brk, m_ext;
  int         m_cnt;
  logic       exp_rdn;
  logic [7:0] exp_st;
  logic       exp_vld;
  logic [2:0] exp_idx;
  logic       exp_rel;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic mdl_reset();
    e = 0; m_acc = -10; m_byte = 8'h00; m_st = 8'h00;
    m_brk = 1'b0; m_ext = 1'b0; m_cnt = 0;
    exp_rdn = 1'b1; exp_st = 8'h00; exp_vld = 1'b0; exp_idx = 3'd0; exp_rel = 1'b0;
  endtask

  task automatic lookup(input logic ext, input logic [7:0] c, output bit hit, output logic [2:0] idx);
    logic [8:0] ent;
    hit = 1'b0; idx = 3'd0;
    for (int i = 0; i < 8; i++) begin
      ent = KMAP[i];
      if (ent == {ext, c}) begin hit = 1'b1; idx = 3'(i); end
    end
  endtask

  // Predict the outputs after the upcoming edge from the inputs now applied
  task automatic predict(input bit ovf);
    bit dec, idle, hit;
    logic [2:0] idx;
    logic mk;
    e++;
    dec = (e == m_acc + 2);
    idle = (e > m_acc + 2);
    exp_vld = 1'b0;
    if (ovf) begin
      m_st = 8'h00; m_brk = 1'b0; m_ext = 1'b0; m_cnt = 0;
    end else if (dec) begin
      m_cnt = 0;
      if (m_byte == 8'hF0) m_brk = 1'b1;
      else if (m_byte == 8'hE0) m_ext = 1'b1;
      else begin
        lookup(m_ext, m_byte, hit, idx);
        if (hit) begin
          mk = !m_brk;
          if (!FILT || (m_st[idx] != mk)) begin
            exp_vld = 1'b1; exp_idx = idx; exp_rel = m_brk;
          end
          m_st[idx] = mk;
        end
        m_brk = 1'b0; m_ext = 1'b0;
      end
    end else if (m_brk || m_ext) begin
      if (idle && q.size() == 0) begin
        m_cnt++;
        if (m_cnt == T) begin m_brk = 1'b0; m_ext = 1'b0; m_cnt = 0; end
      end
    end else begin
      m_cnt = 0;
    end
    if (idle && q.size() != 0) begin m_acc = e; m_byte = q[0]; end
    exp_rdn = (e == m_acc) ? 1'b0 : 1'b1;
    exp_st = m_st;
  endtask

  // One clock: FIFO pop on the strobe, drive the head, predict, advance
  task automatic cyc(input bit ovf);
    if (kb_rdn === 1'b0 && q.size() != 0) void'(q.pop_front());
    kb_ready = (q.size() != 0);
    kb_data = kb_ready ? q[0] : 8'h00;
    kb_overflow = ovf;
    predict(ovf);
    @(negedge clk);
  endtask

  task automatic feed(input logic [7:0] b);
    q.push_back(b);
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while ((q.size() != 0 || (e + 1 <= m_acc + 2)) && guard < 300) begin
      cyc(1'b0);
      guard++;
    end
    if (guard >= 300) begin
      n_chk++; n_err++;
      $display("FAIL drain: FIFO not emptied within 300 cycles");
    end
    cyc(1'b0);
  endtask

  function automatic logic [7:0] rand_byte();
    int r;
    logic [8:0] ent;
    r = $urandom_range(0, 99);
    if (r < 15) return 8'hF0;
    if (r < 30) return 8'hE0;
    if (r < 80) begin
      ent = KMAP[$urandom_range(0, 7)];
      return ent[7:0];
    end
    return 8'($urandom_range(0, 255));
  endfunction

  // Per-cycle compare against the model
  always @(posedge clk) begin
    #1;
    if (chk_en) begin
      chk("kb_rdn", 32'(kb_rdn), 32'(exp_rdn));
      chk("key_state", 32'(key_state), 32'(exp_st));
      chk("key_valid", 32'(key_valid), 32'(exp_vld));
      if (exp_vld) begin
        chk("key_idx", 32'(key_idx), 32'(exp_idx));
        chk("key_released", 32'(key_released), 32'(exp_rel));
      end
      if (key_valid === 1'b1) pulses++;
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0, nb, gap;
    mdl_reset();
    chk_en = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset kb_rdn", 32'(kb_rdn), 32'h1);
    chk("reset key_state", 32'(key_state), 32'h0);
    chk("reset key_idx", 32'(key_idx), 32'h0);
    chk("reset key_released", 32'(key_released), 32'h0);
    rst = 1'b0;

    // Space make: pop one cycle, event three edges after ready
    feed(8'h29);
    cyc(1'b0);
    chk("pop strobe low", 32'(kb_rdn), 32'h0);
    cyc(1'b0);
    chk("pop strobe one cycle", 32'(kb_rdn), 32'h1);
    chk("state before decode", 32'(key_state), 32'h0);
    cyc(1'b0);
    chk("space make state", 32'(key_state), 32'h10);
    chk("space make valid", 32'(key_valid), 32'h1);
    chk("space make idx", 32'(key_idx), 32'h4);
    chk("space make released", 32'(key_released), 32'h0);
    drain();

    // Space break: F0 silent, 29 releases
    p0 = pulses;
    feed(8'hF0); feed(8'h29); drain();
    chk("space break state", 32'(key_state), 32'h0);
    chk("space break pulses", 32'(pulses - p0), 32'h1);

    // Extended left arrow make/break, bare 6B misses
    feed(8'hE0); feed(8'h6B); drain();
    chk("left make state", 32'(key_state), 32'h01);
    feed(8'hE0); feed(8'hF0); feed(8'h6B); drain();
    chk("left break state", 32'(key_state), 32'h00);
    p0 = pulses;
    feed(8'h6B); drain();
    chk("bare 6B state", 32'(key_state), 32'h00);
    chk("bare 6B pulses", 32'(pulses - p0), 32'h0);

    // Typematic repeats
    p0 = pulses;
    feed(8'h29); feed(8'h29); feed(8'h29); drain();
    chk("typematic state", 32'(key_state), 32'h10);
    chk("typematic pulses", 32'(pulses - p0), FILT ? 32'h1 : 32'h3);
    feed(8'hF0); feed(8'h29); drain();

    // Prefix timeout: long gap discards E0, short gap keeps it
    feed(8'hE0); drain();
    repeat (20) cyc(1'b0);
    feed(8'h6B); drain();
    chk("timeout expired state", 32'(key_state), 32'h00);
    feed(8'hE0); drain();
    repeat (8) cyc(1'b0);
    feed(8'h6B); drain();
    chk("timeout kept state", 32'(key_state), 32'h01);
    feed(8'hE0); feed(8'hF0); feed(8'h6B); drain();

    // Overflow clears the bitmap without an event
    feed(8'h1C); feed(8'h76); drain();
    chk("held A+esc", 32'(key_state), 32'hC0);
    p0 = pulses;
    cyc(1'b1); cyc(1'b0); cyc(1'b0);
    chk("overflow state", 32'(key_state), 32'h00);
    chk("overflow pulses", 32'(pulses - p0), 32'h0);

    // Overflow on the decode edge drops the byte
    p0 = pulses;
    feed(8'h29);
    cyc(1'b0); cyc(1'b0); cyc(1'b1);
    drain();
    chk("dropped byte state", 32'(key_state), 32'h00);
    chk("dropped byte pulses", 32'(pulses - p0), 32'h0);

    // Reset in the middle of the pop cycle
    feed(8'h1C); drain();
    feed(8'h29);
    cyc(1'b0);
    chk("pre-reset pop", 32'(kb_rdn), 32'h0);
    q.delete();
    rst = 1'b1;
    #1;
    chk("mid-pop reset kb_rdn", 32'(kb_rdn), 32'h1);
    chk("mid-pop reset key_state", 32'(key_state), 32'h0);
    chk("mid-pop reset key_valid", 32'(key_valid), 32'h0);
    chk("mid-pop reset key_idx", 32'(key_idx), 32'h0);
    chk("mid-pop reset key_released", 32'(key_released), 32'h0);
    mdl_reset();
    kb_ready = 1'b0; kb_data = 8'h00; kb_overflow = 1'b0;
    @(negedge clk); @(negedge clk);
    rst = 1'b0;

    // Randomized byte streams with occasional overflow
    for (int it = 0; it < 300; it++) begin
      nb = $urandom_range(1, 3);
      for (int k = 0; k < nb; k++) feed(rand_byte());
      gap = $urandom_range(0, 30);
      for (int k = 0; k < gap; k++) cyc($urandom_range(0, 59) == 0);
    end
    drain();

    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
